// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: default data width
// and the control strobe bundle exchanged between controller and datapath.
package mul_pkg;

    localparam int MUL_WIDTH_DEFAULT = 16;

    // Strobes issued by the multiplier controller, one bit per datapath action.
    typedef struct packed {
        logic ldA;
        logic ldB;
        logic ldP;
        logic clrP;
        logic decB;
        logic done;
    } mul_ctrl_t;

endpackage

// File: rtl/mul_ld_reg.sv
// WIDTH-bit register with load enable and asynchronous active-low reset to 0.
module mul_ld_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Hold the stored value unless the load enable is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mul_datapath.sv
// Datapath of the repeated-addition multiplier: P accumulates A once per ldP
// while B counts down; eqz reports B == 0 back to the controller. The product
// is captured on the rising edge of done and offered downstream over
// valid/ready.
// Optional build macro ACC_OVF_DETECT_EN adds a sticky accumulator overflow
// flag on ovf; without it ovf is constant 0.
module mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ldA,
    input  logic             ldB,
    input  logic             ldP,
    input  logic             clrP,
    input  logic             decB,
    input  logic             done,
    output logic             eqz,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             ovf
);

    mul_ctrl_t        ctrl;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] p_reg;
    logic             done_q_reg;
    logic             res_valid_reg;
    logic             capture;

    // Bundle the loose strobes so the rest of the datapath reads them by name.
    assign ctrl = {ldA, ldB, ldP, clrP, decB, done};

    // A operand register; a same-cycle ldP still sees the previous A.
    mul_ld_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.ldA),
        .d     (data_in),
        .q     (a_q)
    );

    // B down-counter; a load takes precedence over a decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg <= '0;
        end else if (ctrl.ldB) begin
            b_reg <= data_in;
        end else if (ctrl.decB) begin
            b_reg <= b_reg - 1'b1;
        end
    end

    assign eqz = (b_reg == '0);

    // P accumulator; clear takes precedence over add, add wraps modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
        end else if (ctrl.clrP) begin
            p_reg <= '0;
        end else if (ctrl.ldP) begin
            p_reg <= p_reg + a_q;
        end
    end

    // Delayed done so that only its 0->1 transition triggers a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q_reg <= 1'b0;
        end else begin
            done_q_reg <= ctrl.done;
        end
    end

    assign capture = ctrl.done & ~done_q_reg;

    // Result register samples P as it stands before this cycle's update.
    mul_ld_reg #(.WIDTH(WIDTH)) u_reg_res (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (capture),
        .d     (p_reg),
        .q     (res_data)
    );

    // Valid is set by a capture and cleared by an accepting handshake; a new
    // capture in the accepting cycle keeps it asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
        end else if (capture) begin
            res_valid_reg <= 1'b1;
        end else if (res_valid_reg && res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign res_valid = res_valid_reg;

`ifdef ACC_OVF_DETECT_EN
    logic [WIDTH:0] sum_ext;
    logic           ovf_reg;

    assign sum_ext = {1'b0, p_reg} + {1'b0, a_q};

    // Sticky carry-out flag; clrP clears it even if a carry occurs in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (ctrl.clrP) begin
            ovf_reg <= 1'b0;
        end else if (ctrl.ldP && sum_ext[WIDTH]) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mul_datapath.sv
// Directed testbench for mul_datapath: a 16-bit instance for the main
// function and handshake, an 8-bit instance for accumulator wrap and ovf.
module tb_mul_datapath;

    logic        clk;
    logic        rst_n;
    logic [15:0] data16;
    logic [7:0]  data8;
    logic        ldA, ldB, ldP, clrP, decB, done, res_ready;

    logic        eqz16, valid16, ovf16;
    logic [15:0] res16;
    logic        eqz8, valid8, ovf8;
    logic [7:0]  res8;

    int checks_total;
    int checks_passed;

    mul_datapath #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data16),
        .ldA       (ldA),
        .ldB       (ldB),
        .ldP       (ldP),
        .clrP      (clrP),
        .decB      (decB),
        .done      (done),
        .eqz       (eqz16),
        .res_data  (res16),
        .res_valid (valid16),
        .res_ready (res_ready),
        .ovf       (ovf16)
    );

    mul_datapath #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data8),
        .ldA       (ldA),
        .ldB       (ldB),
        .ldP       (ldP),
        .clrP      (clrP),
        .decB      (decB),
        .done      (done),
        .eqz       (eqz8),
        .res_data  (res8),
        .res_valid (valid8),
        .res_ready (res_ready),
        .ovf       (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("check %-14s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ldA = 0; ldB = 0; ldP = 0; clrP = 0; decB = 0;
    endtask

    // Produce a done rising edge; the product is captured on the second edge.
    task automatic capture();
        idle();
        done = 0;
        tick();
        done = 1;
        tick();
        done = 0;
    endtask

    task automatic accept();
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    logic ovf_exp;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        data16 = 0; data8 = 0; done = 0; res_ready = 0;
        idle();
        rst_n = 0;
        #12;
        check("rst_eqz",   eqz16,   1);
        check("rst_valid", valid16, 0);
        check("rst_data",  res16,   0);
        check("rst_ovf",   ovf16,   0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // 5 * 3
        data16 = 5; ldA = 1; tick(); idle();
        data16 = 3; ldB = 1; tick(); idle();
        check("b3_eqz", eqz16, 0);
        clrP = 1; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            ldP = 1; decB = 1; tick(); idle();
            check("cnt_eqz", eqz16, (i == 2) ? 1 : 0);
        end
        done = 1; tick();
        check("p15_data",  res16,   15);
        check("p15_valid", valid16, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", valid16, 1);
            check("hold_data",  res16,   15);
        end
        res_ready = 1; tick(); res_ready = 0;
        check("accept_valid", valid16, 0);
        done = 0;

        // B loaded with zero
        data16 = 0; ldB = 1; tick(); idle();
        check("b0_eqz", eqz16, 1);
        clrP = 1; tick(); idle();
        capture();
        check("zero_data",  res16,   0);
        check("zero_valid", valid16, 1);
        accept();
        check("zero_accept", valid16, 0);

        // ldP together with clrP leaves P at zero (A is still 5)
        ldP = 1; tick(); idle();
        ldP = 1; clrP = 1; tick(); idle();
        capture();
        check("clr_over_ld", res16, 0);
        accept();

        // ldB together with decB loads 7
        data16 = 7; ldB = 1; decB = 1; tick(); idle();
        check("ldb7_eqz", eqz16, 0);
        for (int i = 0; i < 7; i++) begin
            decB = 1; tick(); idle();
        end
        check("ldb7_count", eqz16, 1);

        // ldA together with ldP: first add uses old A=5, then new A=9
        clrP = 1; tick(); idle();
        data16 = 9; ldA = 1; ldP = 1; tick(); idle();
        ldP = 1; tick(); idle();
        capture();
        check("old_a_sum", res16, 14);

        // Capture while valid and not ready overwrites: 14 + 9 = 23
        ldP = 1; tick(); idle();
        capture();
        check("ovwr_data",  res16,   23);
        check("ovwr_valid", valid16, 1);

        // Asynchronous reset mid-count
        data16 = 2; ldB = 1; tick(); idle();
        check("mid_eqz", eqz16, 0);
        #2;
        rst_n = 0;
        #1;
        check("arst_eqz",   eqz16,   1);
        check("arst_valid", valid16, 0);
        check("arst_data",  res16,   0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // 8-bit wrap: 200 * 2 = 400 mod 256 = 144
`ifdef ACC_OVF_DETECT_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        clrP = 1; tick(); idle();
        data8 = 200; data16 = 200; ldA = 1; tick(); idle();
        data8 = 2;   data16 = 2;   ldB = 1; tick(); idle();
        ldP = 1; decB = 1; tick(); idle();
        check("ovf_first", ovf8, 0);
        ldP = 1; decB = 1; tick(); idle();
        check("w8_eqz", eqz8, 1);
        check("w8_ovf", ovf8, ovf_exp);
        check("w16_ovf", ovf16, 0);
        capture();
        check("w8_data", res8, 144);
        check("w16_data", res16, 400);
        clrP = 1; tick(); idle();
        check("ovf_clr", ovf8, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
